mux_scan_sequencer: RTL

- Upstream/downstream companion to the 4:1 combinational mux.
- Drives the mux select, dwells on each channel, samples the mux output `q`, and assembles a parallel snapshot of all channels.
- Delivers the snapshot through a valid/ready handshake.
- Used to serially read back N_CH input lines through a single mux output. Supports single-shot and continuous scanning.

---
 rtl/mux_scan_if.sv | 20 ++
 rtl/mux_scan_sequencer.sv | 114 +++++++++++
 2 files changed

// File: rtl/mux_scan_if.sv
// Snapshot valid/ready handshake between the scan sequencer and its consumer.
interface mux_scan_if #(
    parameter int N_CH = 4
);
    logic [N_CH-1:0] snap;
    logic            snap_valid;
    logic            snap_ready;

    modport master (
        output snap,
        output snap_valid,
        input  snap_ready
    );

    modport slave (
        input  snap,
        input  snap_valid,
        output snap_ready
    );
endinterface

// File: rtl/mux_scan_sequencer.sv
// Steps a 4:1 mux select, samples its output after a dwell and
// hands the assembled parallel snapshot out over valid/ready.
module mux_scan_sequencer #(
    parameter int N_CH  = 4,
    parameter int SEL_W = 2,
    parameter int DWELL = 2,
    parameter int CNT_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             mode_cont,
    output logic [SEL_W-1:0] sel,
    input  logic             q,
    output logic             busy,
    mux_scan_if.master       snap_if
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_OUT  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DWELL - 1);
    localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_CH - 1);

    state_t            state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    // Last channel's bit goes straight into snap, so the buffer is one short.
    logic [N_CH-2:0]   buf_q, buf_d;
    logic [N_CH-1:0]   snap_q, snap_d;
    logic              valid_q, valid_d;
    logic              busy_q, busy_d;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        buf_d   = buf_q;
        snap_d  = snap_q;
        valid_d = valid_q;
        unique case (state_q)
            S_IDLE: begin
                sel_d = '0;
                if (start) begin
                    state_d = S_SCAN;
                    cnt_d   = '0;
                    sel_d   = '0;
                end
            end
            S_SCAN: begin
                if (cnt_q == LAST_CNT) begin
                    cnt_d = '0;
                    if (sel_q == LAST_SEL) begin
                        snap_d  = {q, buf_q};
                        valid_d = 1'b1;
                        sel_d   = '0;
                        state_d = S_OUT;
                    end else begin
                        buf_d[sel_q] = q;
                        sel_d        = sel_q + SEL_W'(1);
                    end
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            S_OUT: begin
                if (valid_q && snap_if.snap_ready) begin
                    valid_d = 1'b0;
                    if (mode_cont) begin
                        state_d = S_SCAN;
                        cnt_d   = '0;
                        sel_d   = '0;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                sel_d   = '0;
                cnt_d   = '0;
                valid_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            sel_q   <= '0;
            cnt_q   <= '0;
            buf_q   <= '0;
            snap_q  <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            snap_q  <= snap_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
        end
    end

    assign sel                = sel_q;
    assign busy               = busy_q;
    assign snap_if.snap       = snap_q;
    assign snap_if.snap_valid = valid_q;
endmodule
